// File: rtl/shift_req_arbiter.sv
// Two-port round-robin arbiter in front of one 16-bit shifter (SLL/SRA/ROR/pass).
// One operation in flight; the result is registered and held until the owner takes it.
module shift_req_arbiter #(
   parameter logic FIRST_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_op0,
   input  logic [15:0] req_a0,
   input  logic [15:0] req_b0,
   input  logic [1:0]  req_op1,
   input  logic [15:0] req_a1,
   input  logic [15:0] req_b1,
   output logic [1:0]  resp_valid,
   input  logic [1:0]  resp_ready,
   output logic [15:0] resp_data,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q;
   logic        owner_q;
   logic [1:0]  op_q;
   logic [15:0] a_q;
   logic [3:0]  sh_q;
   logic [15:0] resp_data_q;
   logic [15:0] op_count_q;

   logic        grant;
   logic        grant_valid;
   logic        accept;
   logic        resp_done;
   logic [15:0] shift_result;
   logic [31:0] rot_wide;
   logic        unused_b_hi;

   assign unused_b_hi = ^{req_b0[15:4], req_b1[15:4]};

   // Under contention the requester that did not win last time gets the grant.
   always_comb begin
      grant_valid = |req_valid;
      grant       = 1'b0;
      case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant_q;
         default: grant = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      accept     = 1'b0;
      resp_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               req_ready = grant ? 2'b10 : 2'b01;
               accept    = 1'b1;
               state_d   = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            resp_valid = owner_q ? 2'b10 : 2'b01;
            if (resp_ready[owner_q]) begin
               resp_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Rotation is done on a doubled copy so a zero amount needs no special case.
   always_comb begin
      rot_wide     = {a_q, a_q} >> sh_q;
      shift_result = a_q;
      case (op_q)
         2'b00:   shift_result = a_q << sh_q;
         2'b01:   shift_result = $signed(a_q) >>> sh_q;
         2'b10:   shift_result = rot_wide[15:0];
         default: shift_result = a_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= ~FIRST_PRIO;
         owner_q      <= 1'b0;
         op_q         <= 2'b00;
         a_q          <= 16'h0000;
         sh_q         <= 4'h0;
         resp_data_q  <= 16'h0000;
         op_count_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= grant;
            owner_q      <= grant;
            op_q         <= grant ? req_op1 : req_op0;
            a_q          <= grant ? req_a1 : req_a0;
            sh_q         <= grant ? req_b1[3:0] : req_b0[3:0];
         end
         if (state_q == EXEC) begin
            resp_data_q <= shift_result;
         end
         if (resp_done) begin
            op_count_q <= op_count_q + 16'd1;
         end
      end
   end

   assign resp_data = resp_data_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Self-checking bench for shift_req_arbiter: directed, randomized, contention,
// backpressure, reset-in-flight and counter wrap scenarios against a behavioural model.
module tb_shift_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_op0;
   logic [15:0] req_a0;
   logic [15:0] req_b0;
   logic [1:0]  req_op1;
   logic [15:0] req_a1;
   logic [15:0] req_b1;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [15:0] resp_data;
   logic [15:0] op_count;

   int checks   = 0;
   int failures = 0;

   bit          m_last_grant;
   logic [15:0] m_count;

   shift_req_arbiter #(.FIRST_PRIO(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
      .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Reference shifter from the arithmetic definition of each opcode.
   function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      int          sh;
      int          s;
      logic [31:0] v;
      sh = int'(b) % 16;
      case (op)
         2'b00: v = 32'(int'(a) * (1 << sh));
         2'b01: begin
            s = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
            v = 32'(s >>> sh);
         end
         2'b10: v = 32'((int'(a) * 65537) >> sh);
         default: v = 32'(a);
      endcase
      return v[15:0];
   endfunction

   task automatic drive_req(input int p, input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] b);
      if (p == 0) begin
         req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
      end else begin
         req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
      end
   endtask

   task automatic scramble_inputs();
      req_op0 = 2'($urandom); req_a0 = 16'($urandom); req_b0 = 16'($urandom);
      req_op1 = 2'($urandom); req_a1 = 16'($urandom); req_b1 = 16'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      resp_ready = 2'b00;
      scramble_inputs();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_last_grant = 1'b1;
      m_count = 16'h0000;
   endtask

   // Single request from port p; returns what was observed. Called just after a negedge.
   task automatic run_op(input int p, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int stall, output bit acc,
                         output int lat, output logic [1:0] rv, output logic [15:0] rd);
      acc = 1'b0; lat = 0; rv = 2'b00; rd = 16'h0000;
      drive_req(p, op, a, b);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_ready[p]) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!acc) begin
         req_valid = 2'b00;
         return;
      end
      m_last_grant = p[0];
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      scramble_inputs();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid != 2'b00) break;
      end
      rv = resp_valid;
      rd = resp_data;
      repeat (stall) @(negedge clk);
      resp_ready = (p == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      resp_ready = 2'b00;
      if (rv != 2'b00) m_count = m_count + 16'd1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (req_ready !== 2'b00) begin
         failures++; $display("[TB] FAIL reset_req_ready got=%b want=00", req_ready);
      end
      if (resp_valid !== 2'b00) begin
         failures++; $display("[TB] FAIL reset_resp_valid got=%b want=00", resp_valid);
      end
      if (resp_data !== 16'h0000) begin
         failures++; $display("[TB] FAIL reset_resp_data got=%h want=0000", resp_data);
      end
      if (op_count !== 16'h0000) begin
         failures++; $display("[TB] FAIL reset_op_count got=%h want=0000", op_count);
      end
   endtask

   task automatic test_directed();
      int          port [4]    = '{0, 1, 0, 1};
      logic [1:0]  ops  [4]    = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [15:0] as   [4]    = '{16'h0001, 16'h8000, 16'h0001, 16'h1234};
      logic [15:0] bs   [4]    = '{16'h0004, 16'h0003, 16'h0011, 16'h000F};
      logic [15:0] want [4]    = '{16'h0010, 16'hF000, 16'h8000, 16'h1234};
      bit acc; int lat; logic [1:0] rv; logic [15:0] rd; logic [1:0] want_rv;
      for (int i = 0; i < 4; i++) begin
         run_op(port[i], ops[i], as[i], bs[i], 0, acc, lat, rv, rd);
         want_rv = (port[i] == 0) ? 2'b01 : 2'b10;
         checks += 5;
         if (!acc) begin
            failures++; $display("[TB] FAIL directed_accept[%0d] got=0 want=1", i);
         end
         if (lat !== 2) begin
            failures++; $display("[TB] FAIL directed_latency[%0d] got=%0d want=2", i, lat);
         end
         if (rv !== want_rv) begin
            failures++; $display("[TB] FAIL directed_owner[%0d] got=%b want=%b", i, rv, want_rv);
         end
         if (rd !== want[i]) begin
            failures++; $display("[TB] FAIL directed_data[%0d] got=%h want=%h", i, rd, want[i]);
         end
         if (op_count !== m_count) begin
            failures++; $display("[TB] FAIL directed_count[%0d] got=%h want=%h", i, op_count, m_count);
         end
      end
   endtask

   task automatic test_random();
      bit acc; int lat; logic [1:0] rv; logic [15:0] rd;
      int p; logic [1:0] op; logic [15:0] a; logic [15:0] b; logic [15:0] exp_d;
      logic [1:0] want_rv;
      for (int i = 0; i < 30; i++) begin
         p  = int'($urandom_range(0, 1));
         op = 2'($urandom);
         a  = 16'($urandom);
         b  = 16'($urandom);
         exp_d = ref_shift(op, a, b);
         run_op(p, op, a, b, int'($urandom_range(0, 2)), acc, lat, rv, rd);
         want_rv = (p == 0) ? 2'b01 : 2'b10;
         checks += 4;
         if (!acc || lat !== 2) begin
            failures++; $display("[TB] FAIL random_timing[%0d] acc=%0d lat=%0d want acc=1 lat=2", i, acc, lat);
         end
         if (rv !== want_rv) begin
            failures++; $display("[TB] FAIL random_owner[%0d] got=%b want=%b", i, rv, want_rv);
         end
         if (rd !== exp_d) begin
            failures++; $display("[TB] FAIL random_data[%0d] op=%b a=%h b=%h got=%h want=%h", i, op, a, b, rd, exp_d);
         end
         if (op_count !== m_count) begin
            failures++; $display("[TB] FAIL random_count[%0d] got=%h want=%h", i, op_count, m_count);
         end
      end
   endtask

   task automatic test_backpressure();
      bit seen;
      seen = 1'b0;
      drive_req(0, 2'b00, 16'h00F0, 16'h0004);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_ready[0]) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         failures++; $display("[TB] FAIL bp_accept got=0 want=1");
      end
      m_last_grant = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      drive_req(1, 2'b11, 16'hBEEF, 16'h0003);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin
         failures++; $display("[TB] FAIL bp_resp_timeout got=0 want=1");
      end
      resp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         checks += 4;
         if (resp_valid !== 2'b01) begin
            failures++; $display("[TB] FAIL bp_hold_valid[%0d] got=%b want=01", i, resp_valid);
         end
         if (resp_data !== 16'h0F00) begin
            failures++; $display("[TB] FAIL bp_hold_data[%0d] got=%h want=0f00", i, resp_data);
         end
         if (req_ready !== 2'b00) begin
            failures++; $display("[TB] FAIL bp_hold_ready[%0d] got=%b want=00", i, req_ready);
         end
         if (op_count !== m_count) begin
            failures++; $display("[TB] FAIL bp_hold_count[%0d] got=%h want=%h", i, op_count, m_count);
         end
         @(negedge clk);
      end
      resp_ready = 2'b01;
      @(negedge clk);
      resp_ready = 2'b00;
      m_count = m_count + 16'd1;
      #1;
      checks += 2;
      if (op_count !== m_count) begin
         failures++; $display("[TB] FAIL bp_release_count got=%h want=%h", op_count, m_count);
      end
      if (req_ready !== 2'b10) begin
         failures++; $display("[TB] FAIL bp_pending_ready got=%b want=10", req_ready);
      end
      m_last_grant = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      scramble_inputs();
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) begin seen = 1'b1; break; end
      end
      checks += 2;
      if (!seen || resp_valid !== 2'b10) begin
         failures++; $display("[TB] FAIL bp_pending_owner got=%b want=10", resp_valid);
      end
      if (resp_data !== 16'hBEEF) begin
         failures++; $display("[TB] FAIL bp_pending_data got=%h want=beef", resp_data);
      end
      resp_ready = 2'b10;
      @(negedge clk);
      resp_ready = 2'b00;
      if (seen) m_count = m_count + 16'd1;
   endtask

   task automatic test_contention();
      int   n;
      bit   exp_owner;
      logic [1:0]  want_rv;
      logic [15:0] want_d;
      do_reset();
      drive_req(0, 2'b00, 16'h0003, 16'h0001);
      drive_req(1, 2'b00, 16'h0005, 16'h0001);
      resp_ready = 2'b11;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) begin
            exp_owner    = ~m_last_grant;
            m_last_grant = exp_owner;
            want_rv = exp_owner ? 2'b10 : 2'b01;
            want_d  = ref_shift(2'b00, exp_owner ? 16'h0005 : 16'h0003, 16'h0001);
            checks += 2;
            if (resp_valid !== want_rv) begin
               failures++; $display("[TB] FAIL contention_owner[%0d] got=%b want=%b", n, resp_valid, want_rv);
            end
            if (resp_data !== want_d) begin
               failures++; $display("[TB] FAIL contention_data[%0d] got=%h want=%h", n, resp_data, want_d);
            end
            m_count = m_count + 16'd1;
            n++;
         end
      end
      checks++;
      if (n != 4) begin
         failures++; $display("[TB] FAIL contention_responses got=%0d want=4", n);
      end
      @(negedge clk);
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      checks++;
      if (op_count !== 16'd4) begin
         failures++; $display("[TB] FAIL contention_count got=%h want=0004", op_count);
      end
   endtask

   task automatic test_reset_exec();
      bit seen;
      bit rose;
      seen = 1'b0;
      rose = 1'b0;
      drive_req(1, 2'b00, 16'h0001, 16'h0001);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_ready[1]) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_count = 16'h0000;
      m_last_grant = 1'b1;
      checks += 5;
      if (!seen) begin
         failures++; $display("[TB] FAIL rexec_accept got=0 want=1");
      end
      if (resp_valid !== 2'b00) begin
         failures++; $display("[TB] FAIL rexec_resp_valid got=%b want=00", resp_valid);
      end
      if (resp_data !== 16'h0000) begin
         failures++; $display("[TB] FAIL rexec_resp_data got=%h want=0000", resp_data);
      end
      if (op_count !== 16'h0000) begin
         failures++; $display("[TB] FAIL rexec_count got=%h want=0000", op_count);
      end
      if (req_ready !== 2'b00) begin
         failures++; $display("[TB] FAIL rexec_req_ready got=%b want=00", req_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) rose = 1'b1;
      end
      checks += 2;
      if (rose) begin
         failures++; $display("[TB] FAIL rexec_no_resp got=1 want=0");
      end
      if (op_count !== 16'h0000) begin
         failures++; $display("[TB] FAIL rexec_count_after got=%h want=0000", op_count);
      end
   endtask

   task automatic test_wrap();
      bit acc; int lat; logic [1:0] rv; logic [15:0] rd;
      force dut.op_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.op_count_q;
      m_count = 16'hFFFF;
      checks++;
      if (op_count !== 16'hFFFF) begin
         failures++; $display("[TB] FAIL wrap_preload got=%h want=ffff", op_count);
      end
      run_op(0, 2'b10, 16'h0003, 16'h0001, 0, acc, lat, rv, rd);
      checks += 2;
      if (rd !== 16'h8001) begin
         failures++; $display("[TB] FAIL wrap_data got=%h want=8001", rd);
      end
      if (op_count !== 16'h0000) begin
         failures++; $display("[TB] FAIL wrap_count got=%h want=0000", op_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      resp_ready = 2'b00;
      scramble_inputs();
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_contention();
      test_reset_exec();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog_timeout got=running want=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
